mips_pipe_core: RTL and testbench

MIPS_PIPE_CORE -- requirements
Module: mips_pipe_core

---
 rtl/mips_pipe_core.sv | 190 +++++++++++++++++++
 tb/tb_mips_pipe_core.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pipe_core.sv
// mips_pipe_core: three-stage (F, X, W) toy MIPS-like pipeline.
// F latches the instruction at the PC, X reads/forwards registers, computes the ALU
// result and resolves jumps/branches, W writes the register file and retires.
`timescale 1ns/1ps
module mips_pipe_core #(
    parameter int unsigned  DATA_W  = 8,
    parameter int unsigned  REG_AW  = 3,
    parameter int unsigned  IMM_W   = 3,
    parameter int unsigned  ADDR_W  = 8,
    localparam int unsigned INSTR_W = 3 + 2 * REG_AW + IMM_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  instr_addr,
    input  logic [INSTR_W-1:0] instr_data,
    input  logic               instr_valid,
    output logic               wb_en,
    output logic [REG_AW-1:0]  wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic               halted,
    output logic [15:0]        retire_count
);

    localparam int unsigned NREGS = 2 ** REG_AW;
    // Width of the {rd,rs,imm} jump field and the {rs,imm} branch offset.
    localparam int unsigned JW    = 2 * REG_AW + IMM_W;
    localparam int unsigned OW    = REG_AW + IMM_W;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpAddi = 3'd1,
        OpJmp  = 3'd2,
        OpBeqz = 3'd3,
        OpSub  = 3'd4,
        OpNop  = 3'd5,
        OpHalt = 3'd6,
        OpRsvd = 3'd7
    } op_e;

    // Pipeline state
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               fx_valid_q, fx_valid_d;
    logic [INSTR_W-1:0] fx_instr_q, fx_instr_d;
    logic [ADDR_W-1:0]  fx_pc_q, fx_pc_d;
    logic               xw_valid_q;
    logic               xw_we_q;
    logic [REG_AW-1:0]  xw_rd_q;
    logic [DATA_W-1:0]  xw_result_q;
    logic               halted_q;
    logic [15:0]        retire_q;
    logic [DATA_W-1:0]  regs_q [NREGS];

    // X-stage decode
    op_e               x_op;
    logic [REG_AW-1:0] x_rd, x_rs;
    logic [IMM_W-1:0]  x_imm;
    logic [DATA_W-1:0] x_imm_sx;
    logic [DATA_W-1:0] x_rd_val, x_rs_val;
    logic [DATA_W-1:0] x_result;
    logic              x_writes;
    logic              x_redirect;
    logic [ADDR_W-1:0] x_target;
    logic [ADDR_W-1:0] x_jmp_target;
    logic [ADDR_W-1:0] x_br_off;
    logic              x_halt;

    assign x_op  = op_e'(fx_instr_q[INSTR_W-1 -: 3]);
    assign x_rd  = fx_instr_q[IMM_W + REG_AW +: REG_AW];
    assign x_rs  = fx_instr_q[IMM_W +: REG_AW];
    assign x_imm = fx_instr_q[IMM_W-1:0];

    if (DATA_W > IMM_W) begin : g_imm_ext
        assign x_imm_sx = {{(DATA_W - IMM_W){x_imm[IMM_W-1]}}, x_imm};
    end else begin : g_imm_trunc
        assign x_imm_sx = x_imm[DATA_W-1:0];
    end

    if (ADDR_W > JW) begin : g_jmp_ext
        assign x_jmp_target = {{(ADDR_W - JW){1'b0}}, fx_instr_q[JW-1:0]};
    end else begin : g_jmp_trunc
        assign x_jmp_target = fx_instr_q[ADDR_W-1:0];
    end

    if (ADDR_W > OW) begin : g_off_ext
        assign x_br_off = {{(ADDR_W - OW){fx_instr_q[OW-1]}}, fx_instr_q[OW-1:0]};
    end else begin : g_off_trunc
        assign x_br_off = fx_instr_q[ADDR_W-1:0];
    end

    // W's result bypasses the register file when it targets a register X reads.
    assign x_rd_val = (xw_we_q && xw_rd_q == x_rd) ? xw_result_q : regs_q[x_rd];
    assign x_rs_val = (xw_we_q && xw_rd_q == x_rs) ? xw_result_q : regs_q[x_rs];

    assign x_halt = fx_valid_q && (x_op == OpHalt);

    // ALU, write-enable and redirect decode for the instruction in X
    always_comb begin
        x_result   = x_rd_val + x_rs_val;
        x_writes   = 1'b0;
        x_redirect = 1'b0;
        x_target   = x_jmp_target;
        case (x_op)
            OpAdd: begin
                x_writes = 1'b1;
            end
            OpAddi: begin
                x_result = x_rd_val + x_imm_sx;
                x_writes = 1'b1;
            end
            OpSub: begin
                x_result = x_rd_val - x_rs_val;
                x_writes = 1'b1;
            end
            OpJmp: begin
                x_redirect = fx_valid_q;
            end
            OpBeqz: begin
                x_redirect = fx_valid_q && (x_rd_val == '0);
                x_target   = fx_pc_q + x_br_off;
            end
            default: ;
        endcase
    end

    // Fetch next-state: halt freezes, redirect beats instr_valid, stall holds PC
    always_comb begin
        pc_d       = pc_q;
        fx_valid_d = 1'b0;
        fx_instr_d = fx_instr_q;
        fx_pc_d    = fx_pc_q;
        if (!(halted_q || x_halt)) begin
            if (x_redirect) begin
                pc_d = x_target;
            end else if (instr_valid) begin
                pc_d       = pc_q + ADDR_W'(1);
                fx_valid_d = 1'b1;
                fx_instr_d = instr_data;
                fx_pc_d    = pc_q;
            end
        end
    end

    // Pipeline registers, halt flag and retire counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= '0;
            fx_valid_q  <= 1'b0;
            fx_instr_q  <= '0;
            fx_pc_q     <= '0;
            xw_valid_q  <= 1'b0;
            xw_we_q     <= 1'b0;
            xw_rd_q     <= '0;
            xw_result_q <= '0;
            halted_q    <= 1'b0;
            retire_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            fx_valid_q  <= fx_valid_d;
            fx_instr_q  <= fx_instr_d;
            fx_pc_q     <= fx_pc_d;
            xw_valid_q  <= fx_valid_q;
            xw_we_q     <= fx_valid_q && x_writes;
            xw_rd_q     <= x_rd;
            xw_result_q <= x_result;
            halted_q    <= halted_q || x_halt;
            if (xw_valid_q) begin
                retire_q <= retire_q + 16'd1;
            end
        end
    end

    // Register file write from W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (xw_we_q) begin
            regs_q[xw_rd_q] <= xw_result_q;
        end
    end

    assign instr_addr   = pc_q;
    assign wb_en        = xw_we_q;
    assign wb_addr      = xw_rd_q;
    assign wb_data      = xw_result_q;
    assign halted       = halted_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_mips_pipe_core.sv
// Bench for mips_pipe_core: small programs, expected writebacks queued up front and
// matched in order as the core writes them.
`timescale 1ns/1ps
module tb_mips_pipe_core;

    localparam int DATA_W  = 8;
    localparam int REG_AW  = 3;
    localparam int IMM_W   = 3;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 12;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_JMP  = 3'd2;
    localparam logic [2:0] OP_BEQZ = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_NOP  = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [ADDR_W-1:0]  instr_addr;
    logic [INSTR_W-1:0] instr_data;
    logic               instr_valid = 1'b1;
    logic               wb_en;
    logic [REG_AW-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               halted;
    logic [15:0]        retire_count;

    logic [INSTR_W-1:0] imem [256];
    logic [10:0]        sb_q [$];
    logic [10:0]        sb_exp;
    int                 n_checks = 0;
    int                 n_errors = 0;

    mips_pipe_core #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW),
        .IMM_W (IMM_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_addr  (instr_addr),
        .instr_data  (instr_data),
        .instr_valid (instr_valid),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .halted      (halted),
        .retire_count(retire_count)
    );

    assign instr_data = imem[instr_addr];

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [11:0] enc_jmp(input logic [8:0] t);
        return {OP_JMP, t};
    endfunction

    task automatic push_wb(input logic [2:0] rd, input logic [7:0] data);
        sb_q.push_back({rd, data});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Writeback monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset && wb_en) begin
            check_eq("wb_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                sb_exp = sb_q.pop_front();
                check_eq("wb_rd_data", 32'({wb_addr, wb_data}), 32'(sb_exp));
            end
        end
    end

    // Assert reset away from a clock edge; outputs must clear with no edge
    task automatic reset_assert();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_instr_addr", 32'(instr_addr), 32'd0);
        check_eq("rst_wb_en", 32'(wb_en), 32'd0);
        check_eq("rst_wb_addr", 32'(wb_addr), 32'd0);
        check_eq("rst_wb_data", 32'(wb_data), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_retire", 32'(retire_count), 32'd0);
        for (int i = 0; i < 256; i++) begin
            imem[i] = enc(OP_NOP, 3'd0, 3'd0, 3'd0);
        end
        sb_q.delete();
        instr_valid = 1'b1;
    endtask

    task automatic reset_release();
        step();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_pc(input string tag, input logic [7:0] target, input int budget);
        int n = 0;
        while (instr_addr != target && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, 32'(instr_addr), 32'(target));
    endtask

    task automatic run_to_halt(input string tag, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            step();
            n++;
        end
        check_eq({tag, "_halted"}, 32'(halted), 32'd1);
        step();
        step();
    endtask

    task automatic end_checks(input string tag, input logic [7:0] exp_pc, input int exp_ret);
        check_eq({tag, "_pc"}, 32'(instr_addr), 32'(exp_pc));
        check_eq({tag, "_retire"}, 32'(retire_count), 32'(exp_ret));
        check_eq({tag, "_sb_drain"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Forwarding: ADDI r1,+3 then ADD r1,r1 back to back
        reset_assert();
        imem[0] = enc(OP_ADDI, 3'd1, 3'd0, 3'b011);
        imem[1] = enc(OP_ADD, 3'd1, 3'd1, 3'd0);
        imem[2] = enc(OP_HALT, 3'd0, 3'd0, 3'd0);
        push_wb(3'd1, 8'h03);
        push_wb(3'd1, 8'h06);
        reset_release();
        step();
        step();
        check_eq("fwd_first_wb", 32'({wb_en, wb_addr, wb_data}), 32'({1'b1, 3'd1, 8'h03}));
        step();
        check_eq("fwd_second_wb", 32'({wb_en, wb_addr, wb_data}), 32'({1'b1, 3'd1, 8'h06}));
        run_to_halt("fwd", 20);
        end_checks("fwd", 8'h03, 3);

        // Data wrap and register-file visibility after W
        reset_assert();
        imem[0] = enc(OP_ADDI, 3'd2, 3'd0, 3'b111);
        imem[1] = enc(OP_SUB, 3'd3, 3'd2, 3'd0);
        imem[2] = enc(OP_NOP, 3'd0, 3'd0, 3'd0);
        imem[3] = enc(OP_ADD, 3'd4, 3'd3, 3'd0);
        imem[4] = enc(OP_ADD, 3'd4, 3'd2, 3'd0);
        imem[5] = enc(OP_HALT, 3'd0, 3'd0, 3'd0);
        push_wb(3'd2, 8'hFF);
        push_wb(3'd3, 8'h01);
        push_wb(3'd4, 8'h01);
        push_wb(3'd4, 8'h00);
        reset_release();
        run_to_halt("wrap", 30);
        end_checks("wrap", 8'h06, 6);

        // Redirect: JMP 0x20 at 0x02, the instruction at 0x03 is discarded
        reset_assert();
        imem[0]    = enc(OP_ADDI, 3'd1, 3'd0, 3'b010);
        imem[1]    = enc(OP_NOP, 3'd0, 3'd0, 3'd0);
        imem[2]    = enc_jmp(9'h020);
        imem[3]    = enc(OP_ADDI, 3'd6, 3'd0, 3'b001);
        imem[8'h20] = enc(OP_HALT, 3'd0, 3'd0, 3'd0);
        push_wb(3'd1, 8'h02);
        reset_release();
        wait_pc("jmp_reach", 8'h02, 10);
        step();
        check_eq("jmp_in_x_pc", 32'(instr_addr), 32'h03);
        step();
        check_eq("jmp_target_pc", 32'(instr_addr), 32'h20);
        run_to_halt("jmp", 20);
        end_checks("jmp", 8'h21, 4);

        // PC wrap 0xFF -> 0x00 via a truncated jump, BEQZ with forwarded rd
        reset_assert();
        imem[0]     = enc(OP_BEQZ, 3'd5, 3'b010, 3'b000);
        imem[1]     = enc(OP_HALT, 3'd0, 3'd0, 3'd0);
        imem[8'h10] = enc_jmp(9'h1FF);
        imem[8'hFF] = enc(OP_ADDI, 3'd5, 3'd0, 3'b001);
        push_wb(3'd5, 8'h01);
        reset_release();
        wait_pc("pcwrap_reach", 8'hFF, 20);
        step();
        check_eq("pcwrap_zero", 32'(instr_addr), 32'h00);
        run_to_halt("pcwrap", 20);
        end_checks("pcwrap", 8'h02, 5);

        // BEQZ at 0x10 with offset -2: taken while r1==0, falls through once r1==1
        reset_assert();
        imem[0]     = enc_jmp(9'h010);
        imem[8'h0E] = enc(OP_ADDI, 3'd1, 3'd0, 3'b001);
        imem[8'h0F] = enc(OP_NOP, 3'd0, 3'd0, 3'd0);
        imem[8'h10] = enc(OP_BEQZ, 3'd1, 3'b111, 3'b110);
        imem[8'h11] = enc(OP_HALT, 3'd0, 3'd0, 3'd0);
        push_wb(3'd1, 8'h01);
        reset_release();
        wait_pc("beqz_reach1", 8'h10, 10);
        step();
        check_eq("beqz_x_pc1", 32'(instr_addr), 32'h11);
        step();
        check_eq("beqz_taken", 32'(instr_addr), 32'h0E);
        wait_pc("beqz_reach2", 8'h10, 10);
        step();
        check_eq("beqz_x_pc2", 32'(instr_addr), 32'h11);
        step();
        check_eq("beqz_not_taken", 32'(instr_addr), 32'h12);
        run_to_halt("beqz", 20);
        end_checks("beqz", 8'h12, 6);

        // Fetch stall for two cycles
        reset_assert();
        imem[0] = enc(OP_ADDI, 3'd1, 3'd0, 3'b001);
        imem[1] = enc(OP_ADDI, 3'd1, 3'd0, 3'b001);
        imem[2] = enc(OP_ADDI, 3'd1, 3'd0, 3'b001);
        imem[3] = enc(OP_HALT, 3'd0, 3'd0, 3'd0);
        push_wb(3'd1, 8'h01);
        push_wb(3'd1, 8'h02);
        push_wb(3'd1, 8'h03);
        reset_release();
        step();
        step();
        instr_valid = 1'b0;
        step();
        check_eq("stall_pc1", 32'(instr_addr), 32'h02);
        step();
        check_eq("stall_pc2", 32'(instr_addr), 32'h02);
        check_eq("stall_wb_en1", 32'(wb_en), 32'd0);
        check_eq("stall_retire1", 32'(retire_count), 32'd2);
        instr_valid = 1'b1;
        step();
        check_eq("stall_wb_en2", 32'(wb_en), 32'd0);
        check_eq("stall_retire2", 32'(retire_count), 32'd2);
        step();
        check_eq("stall_resume_wb", 32'(wb_en), 32'd1);
        run_to_halt("stall", 20);
        end_checks("stall", 8'h04, 4);

        // HALT at 0x05 after five instructions, then reset while halted
        reset_assert();
        for (int i = 0; i < 5; i++) begin
            imem[i] = enc(OP_ADDI, 3'd7, 3'd0, 3'b001);
        end
        imem[5] = enc(OP_HALT, 3'd0, 3'd0, 3'd0);
        for (int i = 1; i <= 5; i++) begin
            push_wb(3'd7, 8'(i));
        end
        reset_release();
        run_to_halt("halt", 30);
        end_checks("halt", 8'h06, 6);
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        check_eq("halt_frozen_pc", 32'(instr_addr), 32'h06);
        check_eq("halt_frozen_retire", 32'(retire_count), 32'd6);
        check_eq("halt_sticky", 32'(halted), 32'd1);
        reset_assert();
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
